// File: rtl/irq_pkg.sv
// Shared types and helpers for the external interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel index; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection over the eligible channel set.
module irq_arbiter import irq_pkg::*; #(
  parameter int NCH     = 8,
  parameter int RR_MODE = ARB_FIXED,
  localparam int IDW    = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] elig,
  input  logic [IDW-1:0] rr_ptr,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam logic [IDW:0] NCH_W = (IDW + 1)'(NCH);

  logic [NCH-1:0] rot_s;
  logic [IDW-1:0] off_s;
  logic [IDW:0]   sum_s;

  // Round-robin rotates elig so rr_ptr lands at bit 0, then adds the offset back.
  always_comb begin
    grant_valid = |elig;
    grant_id    = '0;
    rot_s       = NCH'({elig, elig} >> rr_ptr);
    off_s       = '0;
    sum_s       = '0;
    if (RR_MODE == ARB_RR) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        off_s = rot_s[k] ? IDW'(k) : off_s;
      end
      sum_s    = {1'b0, rr_ptr} + {1'b0, off_s};
      grant_id = (sum_s >= NCH_W) ? IDW'(sum_s - NCH_W) : sum_s[IDW-1:0];
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        grant_id = elig[k] ? IDW'(k) : grant_id;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-channel masked, prioritised interrupt controller driving ExtIRQ.
// Holds synchroniser, edge detect, pending/mask state, request FSM and rr pointer.
module irq_controller import irq_pkg::*; #(
  parameter int             NCH         = 8,
  parameter logic [NCH-1:0] EDGE_MASK   = {NCH{1'b1}},
  parameter int             RR_MODE     = ARB_FIXED,
  parameter int             SYNC_STAGES = 2,
  localparam int            IDW         = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq_in,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wdata,
  output logic           ExtIRQ,
  input  logic           ExtIAck,
  input  logic           ERet,
  output logic [IDW-1:0] irq_id,
  output logic [NCH-1:0] pending,
  output logic           busy
);

  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH - 1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NCH - 1);

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
  logic [NCH-1:0] prev_q, prev_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] inservice_q, inservice_d;
  irq_state_t     state_q, state_d;
  logic           extirq_q, extirq_d;
  logic           busy_q, busy_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0] s_irq_s, rise_s, elig_s, clr_s, id_onehot_s;
  logic           grant_valid_s;
  logic [IDW-1:0] grant_id_s;

  assign s_irq_s     = sync_q[SYNC_STAGES-1];
  assign rise_s      = s_irq_s & ~prev_q;
  assign elig_s      = pending_q & mask_q & ~inservice_q;
  assign id_onehot_s = ONE_HOT0 << irq_id_q;

  irq_arbiter #(
    .NCH     (NCH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .elig        (elig_s),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Input path: a fresh edge overrides an ack clear in the same cycle.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], irq_in};
    prev_d    = s_irq_s;
    mask_d    = mask_we ? mask_wdata : mask_q;
    pending_d = (((pending_q & ~clr_s) | rise_s) & EDGE_MASK) | (s_irq_s & ~EDGE_MASK);
  end

  // Request FSM: irq_id is frozen from IDLE exit until service completes.
  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    inservice_d = inservice_q;
    rr_ptr_d    = rr_ptr_q;
    clr_s       = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          irq_id_d = grant_id_s;
          state_d  = REQ;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          clr_s       = id_onehot_s & EDGE_MASK;
          inservice_d = id_onehot_s;
          rr_ptr_d    = (irq_id_q == LAST_ID) ? '0 : irq_id_q + IDW'(1);
          state_d     = SERVICE;
        end else begin
          state_d     = REQ;
        end
      end
      SERVICE: begin
        if (ERet) begin
          inservice_d = '0;
          state_d     = IDLE;
        end else begin
          state_d     = SERVICE;
        end
      end
      default: begin
        inservice_d = '0;
        state_d     = IDLE;
      end
    endcase
    extirq_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q      <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      inservice_q <= '0;
      state_q     <= IDLE;
      extirq_q    <= 1'b0;
      busy_q      <= 1'b0;
      irq_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      inservice_q <= inservice_d;
      state_q     <= state_d;
      extirq_q    <= extirq_d;
      busy_q      <= busy_d;
      irq_id_q    <= irq_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign ExtIRQ  = extirq_q;
  assign busy    = busy_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench: a fixed-priority all-edge instance and a round-robin mixed-mode instance.
module tb_irq_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mask_we, ExtIAck, ERet, ExtIRQ, busy;
  logic [7:0] irq_in, mask_wdata, pending;
  logic [2:0] irq_id;

  logic       rr_reset, r_mask_we, r_ack, r_eret, r_extirq, r_busy;
  logic [7:0] r_irq_in, r_mask_wdata, r_pending;
  logic [2:0] r_irq_id;

  irq_controller #(.NCH(8), .RR_MODE(0)) u_fix (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ExtIRQ(ExtIRQ), .ExtIAck(ExtIAck), .ERet(ERet), .irq_id(irq_id), .pending(pending), .busy(busy)
  );

  irq_controller #(.NCH(8), .EDGE_MASK(8'hF0), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(rr_reset), .irq_in(r_irq_in), .mask_we(r_mask_we), .mask_wdata(r_mask_wdata),
    .ExtIRQ(r_extirq), .ExtIAck(r_ack), .ERet(r_eret), .irq_id(r_irq_id), .pending(r_pending), .busy(r_busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_fix[$];
  int exp_rr[$];
  logic [7:0] pend_m;
  logic [7:0] epend_m;
  int ptr_m;
  logic fix_prev = 1'b0;
  logic rr_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int lowest(input logic [7:0] e);
    for (int k = 0; k < 8; k++) if (e[k]) return k;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [7:0] e, input int p);
    for (int k = 0; k < 8; k++) if (e[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  // Monitors: every new request is matched against the next expected channel.
  always @(negedge clk) begin
    if (ExtIRQ && !fix_prev) begin
      if (exp_fix.size() == 0) chk("fix_unexpected_req", int'(irq_id), -1);
      else chk("fix_req_id", int'(irq_id), exp_fix.pop_front());
    end
    fix_prev <= ExtIRQ;
  end

  always @(negedge clk) begin
    if (r_extirq && !rr_prev) begin
      if (exp_rr.size() == 0) chk("rr_unexpected_req", int'(r_irq_id), -1);
      else chk("rr_req_id", int'(r_irq_id), exp_rr.pop_front());
    end
    rr_prev <= r_extirq;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wdata = m; mask_we = 1'b1;
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] p);
    irq_in = irq_in | p;
    tick(2);
    irq_in = irq_in & ~p;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!ExtIRQ && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!ExtIRQ) chk("fix_req_timeout", cyc, -1);
  endtask

  task automatic serve(input bit with_eret);
    ExtIAck = 1'b1; ERet = with_eret;
    @(negedge clk);
    ExtIAck = 1'b0; ERet = 1'b0;
    chk("fix_irq_drop_after_ack", int'(ExtIRQ), 0);
    chk("fix_busy_in_service", int'(busy), 1);
    ERet = 1'b1;
    @(negedge clk);
    ERet = 1'b0;
  endtask

  task automatic drain(input logic [7:0] m);
    int w, cyc;
    write_mask(m);
    while ((pend_m & m) != 8'h00) begin
      w = lowest(pend_m & m);
      exp_fix.push_back(w);
      wait_req(cyc);
      serve($urandom_range(0, 1) == 1);
      pend_m[w] = 1'b0;
    end
  endtask

  task automatic rr_write_mask(input logic [7:0] m);
    r_mask_wdata = m; r_mask_we = 1'b1;
    @(negedge clk);
    r_mask_we = 1'b0;
  endtask

  task automatic rr_wait();
    int cyc = 0;
    while (!r_extirq && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!r_extirq) chk("rr_req_timeout", cyc, -1);
  endtask

  task automatic rr_ack();
    r_ack = 1'b1;
    @(negedge clk);
    r_ack = 1'b0;
    chk("rr_irq_drop_after_ack", int'(r_extirq), 0);
  endtask

  task automatic rr_eret();
    r_eret = 1'b1;
    @(negedge clk);
    r_eret = 1'b0;
  endtask

  initial begin
    int cyc, w;
    logic [7:0] p, m, lv, ep;
    bit last;
    reset = 1'b0; rr_reset = 1'b0; irq_in = 8'hFF; mask_we = 1'b0; mask_wdata = 8'h00;
    ExtIAck = 1'b0; ERet = 1'b0;
    r_irq_in = 8'h00; r_mask_we = 1'b0; r_mask_wdata = 8'h00; r_ack = 1'b0; r_eret = 1'b0;
    pend_m = 8'h00; epend_m = 8'h00; ptr_m = 0;

    // Reset with all sources high.
    tick(3);
    chk("reset_extirq", int'(ExtIRQ), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_irq_id", int'(irq_id), 0);
    reset = 1'b1; rr_reset = 1'b1;
    tick(6);
    chk("post_reset_no_req", int'(ExtIRQ), 0);
    chk("post_reset_busy", int'(busy), 0);
    pend_m = 8'hFF;
    chk("post_reset_pending_edges", int'(pending), int'(pend_m));
    irq_in = 8'h00;
    drain(8'hFF);

    // Fixed priority and latency: input set half a cycle before the sampling edge,
    // ExtIRQ rises three edges later and is first seen at the fourth negedge.
    exp_fix.push_back(2);
    exp_fix.push_back(5);
    irq_in = 8'h24;
    wait_req(cyc);
    chk("fix_edge_to_irq_latency", cyc, 4);
    irq_in = 8'h00;
    serve(1'b0);
    wait_req(cyc);
    serve(1'b0);

    // Masked event latches and fires one clock after the mask write.
    write_mask(8'h00);
    pulse(8'h10);
    tick(3);
    chk("masked_latch_pending", int'(pending), 8'h10);
    chk("masked_latch_no_req", int'(ExtIRQ), 0);
    exp_fix.push_back(4);
    write_mask(8'h10);
    chk("masked_latch_pending4", int'(pending[4]), 1);
    wait_req(cyc);
    chk("mask_to_irq_latency", cyc, 1);
    serve(1'b0);

    // New edge on channel 0 meets the ack that clears it.
    write_mask(8'hFF);
    exp_fix.push_back(0);
    exp_fix.push_back(0);
    pulse(8'h01);
    wait_req(cyc);
    irq_in[0] = 1'b1;
    tick(2);
    ExtIAck = 1'b1;
    irq_in[0] = 1'b0;
    @(negedge clk);
    ExtIAck = 1'b0;
    chk("set_beats_clear_pending0", int'(pending[0]), 1);
    chk("set_beats_clear_busy", int'(busy), 1);
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    wait_req(cyc);
    serve(1'b0);
    chk("set_beats_clear_done", int'(pending[0]), 0);

    // Random patterns against the lowest-index rule.
    for (int it = 0; it < 10; it++) begin
      write_mask(8'h00);
      p = 8'($urandom_range(1, 255));
      pulse(p);
      tick(3);
      pend_m = pend_m | p;
      chk("rand_pending", int'(pending), int'(pend_m));
      m = 8'($urandom_range(0, 255));
      drain(m);
    end

    // Reset while in service abandons the interrupt.
    write_mask(8'h00);
    pulse(8'h40);
    tick(3);
    exp_fix.push_back(6);
    write_mask(8'h40);
    wait_req(cyc);
    ExtIAck = 1'b1;
    @(negedge clk);
    ExtIAck = 1'b0;
    chk("mid_service_busy", int'(busy), 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("mid_reset_extirq", int'(ExtIRQ), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_pending", int'(pending), 0);
    chk("mid_reset_irq_id", int'(irq_id), 0);
    pend_m = 8'h00;
    ERet = 1'b1;
    tick(1);
    ERet = 1'b0;
    tick(1);
    chk("stray_eret_busy", int'(busy), 0);
    pulse(8'h02);
    tick(3);
    chk("mask_cleared_no_req", int'(ExtIRQ), 0);
    chk("mask_cleared_pending", int'(pending), 8'h02);
    pend_m = 8'h02;
    drain(8'hFF);

    // Round-robin over two level channels.
    r_irq_in = 8'h0A;
    tick(4);
    chk("rr_level_pending", int'(r_pending), 8'h0A);
    exp_rr.push_back(1);
    exp_rr.push_back(3);
    exp_rr.push_back(1);
    exp_rr.push_back(3);
    rr_write_mask(8'h0A);
    for (int i = 0; i < 4; i++) begin
      rr_wait();
      rr_ack();
      chk("rr_level_kept_after_ack", int'(r_pending & 8'h0A), 8'h0A);
      if (i == 3) begin
        r_irq_in = 8'h00;
        rr_write_mask(8'h00);
      end
      rr_eret();
    end
    ptr_m = 4;

    // Random mixed level/edge traffic against the rotating-pointer rule.
    for (int it = 0; it < 8; it++) begin
      lv = 8'($urandom_range(0, 15));
      ep = 8'($urandom_range(0, 15)) << 4;
      r_irq_in = lv | ep;
      tick(2);
      r_irq_in = lv;
      tick(4);
      epend_m = epend_m | ep;
      chk("rr_rand_pending", int'(r_pending), int'(epend_m | lv));
      m = 8'($urandom_range(1, 255));
      rr_write_mask(m);
      for (int rnd = 0; rnd < 6; rnd++) begin
        if (((epend_m | lv) & m) == 8'h00) break;
        w = rr_pick((epend_m | lv) & m, ptr_m);
        exp_rr.push_back(w);
        ptr_m = (w + 1) % 8;
        rr_wait();
        rr_ack();
        if (w >= 4) epend_m[w] = 1'b0;
        last = (rnd == 5) || (((epend_m | lv) & m) == 8'h00);
        if (last) begin
          r_irq_in = 8'h00;
          rr_write_mask(8'h00);
        end
        rr_eret();
        if (last) break;
      end
      r_irq_in = 8'h00;
      rr_write_mask(8'h00);
      tick(2);
    end

    tick(5);
    chk("fix_queue_drained", exp_fix.size(), 0);
    chk("rr_queue_drained", exp_rr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
